// File: rtl/haar_database_arbiter.sv
// Round-robin arbiter sharing one single-port Haar parameter memory among the
// classifier stages; a tag pipeline routes each read's data back to its owner.

module haar_db_lane (
  input  logic clk_fpga,
  input  logic reset_fpga,
  input  logic req,
  input  logic set,
  input  logic clr,
  output logic pending,
  output logic eligible
);

  // set and clr never coincide: a stage is only granted while not pending
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga)
      pending <= 1'b0;
    else if (set)
      pending <= 1'b1;
    else if (clr)
      pending <= 1'b0;
  end

  assign eligible = req & ~pending;

endmodule

module haar_database_arbiter #(
  parameter int NUM_STAGES    = 24,
  parameter int DATA_WIDTH_12 = 12,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                                clk_fpga,
  input  logic                                reset_fpga,
  input  logic                                enable,
  input  logic [NUM_STAGES-1:0]               req,
  input  logic [NUM_STAGES*DATA_WIDTH_12-1:0] req_addr,
  input  logic [DATA_WIDTH_12-1:0]            mem_data,
  output logic [DATA_WIDTH_12-1:0]            o_mem_addr,
  output logic                                o_mem_ren,
  output logic [NUM_STAGES-1:0]               o_grant,
  output logic [DATA_WIDTH_12-1:0]            o_data,
  output logic [NUM_STAGES-1:0]               o_data_valid,
  output logic                                o_busy
);

  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [NUM_STAGES-1:0][DATA_WIDTH_12-1:0] addr_arr;
  logic [NUM_STAGES-1:0] pending, eligible, set_vec, clr_vec;
  logic [IW-1:0]         ptr, win_idx, ptr_nxt;
  logic                  win_found, issue;

  // Tag pipeline: entry j is the read issued j cycles ago
  logic [MEM_LATENCY:0]         vld_pipe;
  logic [MEM_LATENCY:0][IW-1:0] idx_pipe;

  assign addr_arr = req_addr;

  genvar g;
  generate
    for (g = 0; g < NUM_STAGES; g++) begin : g_lane
      haar_db_lane u_lane (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .req        (req[g]),
        .set        (set_vec[g]),
        .clr        (clr_vec[g]),
        .pending    (pending[g]),
        .eligible   (eligible[g])
      );
    end
  endgenerate

  // First eligible stage at or after ptr, wrapping
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < NUM_STAGES; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_STAGES)
        cand = cand - NUM_STAGES;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  assign issue   = enable & win_found;
  assign ptr_nxt = (win_idx == IW'(NUM_STAGES - 1)) ? '0 : win_idx + 1'b1;
  assign set_vec = issue ? (NUM_STAGES'(1) << win_idx) : '0;
  assign clr_vec = vld_pipe[MEM_LATENCY] ? (NUM_STAGES'(1) << idx_pipe[MEM_LATENCY]) : '0;

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      ptr          <= '0;
      vld_pipe     <= '0;
      idx_pipe     <= '0;
      o_mem_addr   <= '0;
      o_mem_ren    <= 1'b0;
      o_grant      <= '0;
      o_data       <= '0;
      o_data_valid <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_mem_ren <= issue;
      o_grant   <= set_vec;
      if (issue) begin
        o_mem_addr <= addr_arr[win_idx];
        ptr        <= ptr_nxt;
      end
      vld_pipe     <= {vld_pipe[MEM_LATENCY-1:0], issue};
      idx_pipe     <= {idx_pipe[MEM_LATENCY-1:0], win_idx};
      o_data_valid <= clr_vec;
      if (vld_pipe[MEM_LATENCY])
        o_data <= mem_data;
      // Old pending keeps busy high through the data-valid cycle
      o_busy <= |(pending | set_vec);
    end
  end

endmodule

// File: tb/tb_haar_database_arbiter.sv
// Bench for haar_database_arbiter: directed vector table, a regrant-spacing
// sequence, then random traffic against a transaction-level reference model.

module tb_haar_database_arbiter;

  localparam int N = 4;
  localparam int W = 12;
  localparam int L = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_addr;
  logic [W-1:0]     mem_data;
  logic [W-1:0]     o_mem_addr;
  logic             o_mem_ren;
  logic [N-1:0]     o_grant;
  logic [W-1:0]     o_data;
  logic [N-1:0]     o_data_valid;
  logic             o_busy;

  int checks = 0;
  int errors = 0;

  haar_database_arbiter #(.NUM_STAGES(N), .DATA_WIDTH_12(W), .MEM_LATENCY(L)) dut (
    .clk_fpga     (clk),
    .reset_fpga   (rst),
    .enable       (en),
    .req          (req),
    .req_addr     (req_addr),
    .mem_data     (mem_data),
    .o_mem_addr   (o_mem_addr),
    .o_mem_ren    (o_mem_ren),
    .o_grant      (o_grant),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] memf(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = {a[5:0], a[11:6]};
    return (a * 12'd37 + 12'h15B) ^ r;
  endfunction

  // Memory with 2-cycle read latency; garbage when not read
  logic [W-1:0] m1;
  always @(posedge clk) begin
    m1       <= o_mem_ren ? memf(o_mem_addr) : 12'hEEE;
    mem_data <= m1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, en, scr;
    logic [N-1:0] req;
    logic [N-1:0] g;
    logic ren;
    logic [W-1:0] a;
    logic [N-1:0] dv;
    logic busy;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic e, input logic s, input logic [N-1:0] q,
                     input logic [N-1:0] g, input logic rn, input logic [W-1:0] a,
                     input logic [N-1:0] dv, input logic b);
    vec_t v;
    v.rst = r; v.en = e; v.scr = s; v.req = q; v.g = g; v.ren = rn;
    v.a = a; v.dv = dv; v.busy = b;
    tv.push_back(v);
  endtask

  localparam logic [N*W-1:0] BASE_ADDR = {12'h0D3, 12'h0A5, 12'h07F, 12'h011};
  logic [W-1:0] stage_addr [N] = '{12'h011, 12'h07F, 12'h0A5, 12'h0D3};

  // ---------------- reference model ----------------
  typedef struct { int due; int stage; logic [W-1:0] addr; } rd_t;
  rd_t mq[$];
  bit  mpend [N];
  int  mptr, mcyc;
  logic [N-1:0] e_g, e_dv;
  logic         e_ren, e_busy;
  logic [W-1:0] e_a, e_d;

  task automatic model_step();
    int win;
    bit old_busy, new_busy;
    mcyc++;
    if (rst) begin
      mq.delete();
      foreach (mpend[i]) mpend[i] = 0;
      mptr = 0; e_g = '0; e_dv = '0; e_ren = 0; e_busy = 0; e_a = '0; e_d = '0;
      return;
    end
    old_busy = 0;
    foreach (mpend[i]) old_busy |= mpend[i];
    win = -1;
    if (en) begin
      for (int o = 0; o < N; o++) begin
        int s;
        s = (mptr + o) % N;
        if (req[s] && !mpend[s]) begin win = s; break; end
      end
    end
    e_dv = '0;
    if (mq.size() > 0 && mq[0].due == mcyc) begin
      e_dv[mq[0].stage] = 1'b1;
      e_d = memf(mq[0].addr);
      mpend[mq[0].stage] = 0;
      void'(mq.pop_front());
    end
    e_g = '0; e_ren = 0;
    if (win >= 0) begin
      rd_t t;
      t.due = mcyc + L + 1; t.stage = win; t.addr = req_addr[win*W +: W];
      mq.push_back(t);
      mpend[win] = 1;
      e_g[win] = 1'b1; e_ren = 1; e_a = t.addr;
      mptr = (win + 1) % N;
    end
    new_busy = 0;
    foreach (mpend[i]) new_busy |= mpend[i];
    e_busy = old_busy | new_busy;
  endtask

  initial begin
    int last, cnt;
    rst = 1'b1; en = 1'b0; req = '0; req_addr = BASE_ADDR;

    //  rst en scr req      grant    ren addr     dv       busy
    add(1, 0, 0, 4'b0000, 4'b0000, 0, 12'h000, 4'b0000, 0);
    add(0, 1, 0, 4'b0100, 4'b0100, 1, 12'h0A5, 4'b0000, 1);
    add(0, 1, 1, 4'b0000, 4'b0000, 0, 12'h0A5, 4'b0000, 1);
    add(0, 1, 1, 4'b0000, 4'b0000, 0, 12'h0A5, 4'b0000, 1);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h0A5, 4'b0100, 1);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h0A5, 4'b0000, 0);
    add(1, 1, 0, 4'b1111, 4'b0000, 0, 12'h000, 4'b0000, 0);
    add(0, 1, 0, 4'b1111, 4'b0001, 1, 12'h011, 4'b0000, 1);
    add(0, 1, 0, 4'b1111, 4'b0010, 1, 12'h07F, 4'b0000, 1);
    add(0, 1, 0, 4'b1111, 4'b0100, 1, 12'h0A5, 4'b0000, 1);
    add(0, 1, 0, 4'b1111, 4'b1000, 1, 12'h0D3, 4'b0001, 1);
    add(0, 1, 0, 4'b1111, 4'b0001, 1, 12'h011, 4'b0010, 1);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h011, 4'b0100, 1);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h011, 4'b1000, 1);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h011, 4'b0001, 1);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h011, 4'b0000, 0);
    add(1, 1, 0, 4'b0000, 4'b0000, 0, 12'h000, 4'b0000, 0);
    add(0, 1, 0, 4'b0010, 4'b0010, 1, 12'h07F, 4'b0000, 1);
    add(0, 0, 0, 4'b1111, 4'b0000, 0, 12'h07F, 4'b0000, 1);
    add(0, 0, 0, 4'b1111, 4'b0000, 0, 12'h07F, 4'b0000, 1);
    add(0, 0, 0, 4'b1111, 4'b0000, 0, 12'h07F, 4'b0010, 1);
    add(0, 0, 0, 4'b1111, 4'b0000, 0, 12'h07F, 4'b0000, 0);
    add(0, 0, 0, 4'b1111, 4'b0000, 0, 12'h07F, 4'b0000, 0);
    add(0, 1, 0, 4'b1001, 4'b1000, 1, 12'h0D3, 4'b0000, 1);
    add(0, 1, 0, 4'b1001, 4'b0001, 1, 12'h011, 4'b0000, 1);
    add(1, 1, 0, 4'b1001, 4'b0000, 0, 12'h000, 4'b0000, 0);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h000, 4'b0000, 0);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h000, 4'b0000, 0);
    add(0, 1, 0, 4'b1111, 4'b0001, 1, 12'h011, 4'b0000, 1);
    add(0, 1, 0, 4'b0000, 4'b0000, 0, 12'h011, 4'b0000, 1);

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; en = tv[i].en; req = tv[i].req;
      req_addr = tv[i].scr ? {N*W{1'b1}} : BASE_ADDR;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), 32'(o_grant), 32'(tv[i].g));
      chk($sformatf("v%0d_ren", i), 32'(o_mem_ren), 32'(tv[i].ren));
      chk($sformatf("v%0d_addr", i), 32'(o_mem_addr), 32'(tv[i].a));
      chk($sformatf("v%0d_dvalid", i), 32'(o_data_valid), 32'(tv[i].dv));
      chk($sformatf("v%0d_busy", i), 32'(o_busy), 32'(tv[i].busy));
      for (int s = 0; s < N; s++)
        if (tv[i].dv[s])
          chk($sformatf("v%0d_data", i), 32'(o_data), 32'(memf(stage_addr[s])));
    end

    // Stage 2 held requesting: regrant exactly every L+2 cycles
    rst = 1'b1; req = '0; en = 1'b1; req_addr = BASE_ADDR;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; req = 4'b0100;
    last = -1; cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (o_grant[2]) begin
        if (last >= 0) chk("regrant_gap", 32'(c - last), 32'(L + 2));
        last = c; cnt++;
      end
    end
    chk("regrant_count", 32'(cnt), 32'd5);

    // Random traffic against the reference model
    mcyc = 0;
    for (int c = 0; c < 1500; c++) begin
      rst = (c == 0) || ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 7) != 0);
      req = N'($urandom);
      for (int s = 0; s < N; s++) req_addr[s*W +: W] = W'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd_grant", 32'(o_grant), 32'(e_g));
      chk("rnd_ren", 32'(o_mem_ren), 32'(e_ren));
      chk("rnd_addr", 32'(o_mem_addr), 32'(e_a));
      chk("rnd_dvalid", 32'(o_data_valid), 32'(e_dv));
      chk("rnd_data", 32'(o_data), 32'(e_d));
      chk("rnd_busy", 32'(o_busy), 32'(e_busy));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
